// File: rtl/gfx_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// gfx_rom_arbiter_if
// Bundles the three requester toggle channels and the downstream SDRAM/ROM
// toggle channel of gfx_rom_arbiter.
//
// Handshake (toggle protocol, identical on every channel): a requester flips
// reqN to start a read and keeps req_addrN stable while reqN != ackN. The
// responder flips ackN back to equal reqN in the same cycle dataN becomes
// valid. dataN is held until the next completion on that channel. The
// downstream side works the same way with sdr_req/sdr_ack/sdr_data.
//
// Modports
//   master : the arbiter (serves requesters, drives the downstream request)
//   slave  : the environment (requesters and downstream memory controller)
// -----------------------------------------------------------------------------
interface gfx_rom_arbiter_if #(
    parameter int ADDR_W  = 27,
    parameter int PADDR_W = 21
);
    logic [PADDR_W-1:0] req_addr0;
    logic [PADDR_W-1:0] req_addr1;
    logic [PADDR_W-1:0] req_addr2;
    logic               req0;
    logic               req1;
    logic               req2;
    logic               ack0;
    logic               ack1;
    logic               ack2;
    logic [31:0]        data0;
    logic [31:0]        data1;
    logic [31:0]        data2;

    logic [ADDR_W-1:0]  sdr_addr;
    logic               sdr_req;
    logic               sdr_ack;
    logic [31:0]        sdr_data;

    modport master (
        input  req_addr0, req_addr1, req_addr2,
        input  req0, req1, req2,
        output ack0, ack1, ack2,
        output data0, data1, data2,
        output sdr_addr, sdr_req,
        input  sdr_ack, sdr_data
    );

    modport slave (
        output req_addr0, req_addr1, req_addr2,
        output req0, req1, req2,
        input  ack0, ack1, ack2,
        input  data0, data1, data2,
        input  sdr_addr, sdr_req,
        output sdr_ack, sdr_data
    );
endinterface

// File: rtl/gfx_rom_arbiter.sv
// -----------------------------------------------------------------------------
// gfx_rom_arbiter
// Shares one toggle-handshake SDRAM/ROM read channel among three graphics
// requesters: port 0 = TC0100SCN tile fetch, port 1 = sprite engine,
// port 2 = CPU ROM. Requests are serialised, a per-port byte base offset is
// added to the zero-extended requester address (wrapping modulo 2^ADDR_W),
// and the 32-bit read word is returned on the winning port.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous reset, active low
//   bus        gfx_rom_arbiter_if.master: req_addrN/reqN/ackN/dataN per port,
//              sdr_addr/sdr_req/sdr_ack/sdr_data downstream
//   busy       high while a transfer is being issued or awaited
//   grant      port being serviced (0..2), 3 when idle
//   dbg_state  current FSM state (0 idle, 1 issue, 2 wait)
//
// Configuration macro
//   GFX_ARB_ROUND_ROBIN_EN  undefined: fixed priority 0 > 1 > 2 (port 0 can
//                           starve the others). Defined: rotating priority,
//                           search starts after the last granted port; the
//                           last grant resets to 2 so port 0 goes first.
// -----------------------------------------------------------------------------
module gfx_rom_arbiter #(
    parameter int                ADDR_W  = 27,
    parameter int                PADDR_W = 21,
    parameter logic [ADDR_W-1:0] BASE0   = '0,
    parameter logic [ADDR_W-1:0] BASE1   = '0,
    parameter logic [ADDR_W-1:0] BASE2   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    gfx_rom_arbiter_if.master bus,
    output logic              busy,
    output logic [1:0]        grant,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [2:0]        req_vec;
    logic [2:0]        pend;
    logic              any_pend;
    logic [1:0]        win_sel;
    logic [ADDR_W-1:0] win_addr;

    logic [1:0]        win_port;
    logic              win_req;
    logic [ADDR_W-1:0] sdr_addr_q;
    logic              sdr_req_q;
    logic [2:0]        ack_q;
    logic [31:0]       data_q [3];
    logic              xfer_done;

`ifdef GFX_ARB_ROUND_ROBIN_EN
    logic [1:0]        last_grant;
`endif

    assign req_vec  = {bus.req2, bus.req1, bus.req0};
    assign pend     = req_vec ^ ack_q;
    assign any_pend = |pend;
    // Only meaningful in WAIT: ISSUE has just made sdr_req differ from sdr_ack.
    assign xfer_done = (bus.sdr_ack == sdr_req_q);

    // Winner selection. Only consulted in IDLE, so requests that arrive during
    // ISSUE/WAIT simply compete at the next IDLE.
    always_comb begin
        win_sel = 2'd0;
`ifdef GFX_ARB_ROUND_ROBIN_EN
        case (last_grant)
            2'd0:    win_sel = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
            2'd1:    win_sel = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
            default: win_sel = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
        endcase
`else
        win_sel = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
`endif
    end

    // Base offset plus zero-extended address; the sum wraps in ADDR_W bits.
    always_comb begin
        win_addr = '0;
        case (win_sel)
            2'd0:    win_addr = BASE0 + ADDR_W'(bus.req_addr0);
            2'd1:    win_addr = BASE1 + ADDR_W'(bus.req_addr1);
            default: win_addr = BASE2 + ADDR_W'(bus.req_addr2);
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_pend) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (xfer_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state == S_ISSUE) || (state == S_WAIT);
        grant     = (state == S_IDLE) ? 2'd3 : win_port;
        dbg_state = state;
    end

    // Datapath. ackN takes the request value latched at grant time, so a
    // requester that re-toggles mid-service remains pending and is served again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_port   <= 2'd0;
            win_req    <= 1'b0;
            sdr_addr_q <= '0;
            sdr_req_q  <= 1'b0;
            ack_q      <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= 32'd0;
            end
`ifdef GFX_ARB_ROUND_ROBIN_EN
            last_grant <= 2'd2;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        win_port   <= win_sel;
                        win_req    <= req_vec[win_sel];
                        sdr_addr_q <= win_addr;
`ifdef GFX_ARB_ROUND_ROBIN_EN
                        last_grant <= win_sel;
`endif
                    end
                end
                S_ISSUE: begin
                    sdr_req_q <= ~sdr_req_q;
                end
                S_WAIT: begin
                    if (xfer_done) begin
                        data_q[win_port] <= bus.sdr_data;
                        ack_q[win_port]  <= win_req;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sdr_addr = sdr_addr_q;
    assign bus.sdr_req  = sdr_req_q;
    assign bus.ack0     = ack_q[0];
    assign bus.ack1     = ack_q[1];
    assign bus.ack2     = ack_q[2];
    assign bus.data0    = data_q[0];
    assign bus.data1    = data_q[1];
    assign bus.data2    = data_q[2];

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gfx_rom_arbiter
// Self-checking bench for gfx_rom_arbiter. A downstream memory model answers
// each sdr_req toggle after a programmable delay with a hashed data word; a
// monitor logs every issued transfer (grant, sdr_addr). A reference model
// predicts service order from the priority rules (fixed, or rotating when
// GFX_ARB_ROUND_ROBIN_EN is defined), the expected addresses, acks and data.
// -----------------------------------------------------------------------------
module tb_gfx_rom_arbiter;

    localparam int                ADDR_W  = 27;
    localparam int                PADDR_W = 21;
    localparam logic [ADDR_W-1:0] BASE0   = 27'h010_0000;
    localparam logic [ADDR_W-1:0] BASE1   = 27'h020_0000;
    localparam logic [ADDR_W-1:0] BASE2   = 27'h7FF_FFF0;

    // clock / reset
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       busy;
    logic [1:0] grant;
    logic [1:0] dbg_state;

    gfx_rom_arbiter_if #(.ADDR_W(ADDR_W), .PADDR_W(PADDR_W)) bus ();

    gfx_rom_arbiter #(
        .ADDR_W (ADDR_W),
        .PADDR_W(PADDR_W),
        .BASE0  (BASE0),
        .BASE1  (BASE1),
        .BASE2  (BASE2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.master),
        .busy     (busy),
        .grant    (grant),
        .dbg_state(dbg_state)
    );

    // requester drive
    logic [2:0]         req_v;
    logic [PADDR_W-1:0] addr_v [3];
    assign bus.req0      = req_v[0];
    assign bus.req1      = req_v[1];
    assign bus.req2      = req_v[2];
    assign bus.req_addr0 = addr_v[0];
    assign bus.req_addr1 = addr_v[1];
    assign bus.req_addr2 = addr_v[2];

    wire [2:0]   ack_w = {bus.ack2, bus.ack1, bus.ack0};
    logic [31:0] data_w [3];
    assign data_w[0] = bus.data0;
    assign data_w[1] = bus.data1;
    assign data_w[2] = bus.data2;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return ({5'b0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // downstream memory model: answers after dly extra cycles
    int          dly = 0;
    int          ds_cnt;
    logic        ds_ack;
    logic [31:0] ds_data;
    assign bus.sdr_ack  = ds_ack;
    assign bus.sdr_data = ds_data;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ds_ack  <= 1'b0;
            ds_data <= 32'd0;
            ds_cnt  <= 0;
        end else if (bus.sdr_req != ds_ack) begin
            if (ds_cnt >= dly) begin
                ds_ack  <= bus.sdr_req;
                ds_data <= mem_word(bus.sdr_addr);
                ds_cnt  <= 0;
            end else begin
                ds_cnt <= ds_cnt + 1;
            end
        end
    end

    // monitor: one entry {grant, sdr_addr} per sdr_req toggle
    logic        prev_req;
    logic [28:0] act_q [$];
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_req <= 1'b0;
        end else if (bus.sdr_req !== prev_req) begin
            prev_req <= bus.sdr_req;
            act_q.push_back({grant, bus.sdr_addr});
        end
    end

    // scoreboard / reference model
    logic [28:0] exp_q [$];
    logic [2:0]  m_ack;
    logic [31:0] m_data [3];
`ifdef GFX_ARB_ROUND_ROBIN_EN
    int          m_last;
`endif
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] eff_addr(input int p, input logic [PADDR_W-1:0] a);
        logic [ADDR_W-1:0] b;
        b = (p == 0) ? BASE0 : ((p == 1) ? BASE1 : BASE2);
        return b + ADDR_W'(a);
    endfunction

    // Predict one transfer for port p with its current request/address.
    task automatic model_serve(input int p);
        logic [ADDR_W-1:0] ea;
        ea = eff_addr(p, addr_v[p]);
        exp_q.push_back({2'(p), ea});
        m_ack[p]  = req_v[p];
        m_data[p] = mem_word(ea);
`ifdef GFX_ARB_ROUND_ROBIN_EN
        m_last = p;
`endif
    endtask

    // All ports in mask become pending together while the arbiter is idle:
    // they are served once each, in priority-ring order.
    task automatic model_batch(input logic [2:0] mask);
        int start;
`ifdef GFX_ARB_ROUND_ROBIN_EN
        start = (m_last + 1) % 3;
`else
        start = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            int p;
            p = (start + i) % 3;
            if (mask[p]) model_serve(p);
        end
    endtask

    // driver tasks
    task automatic launch(input logic [2:0] mask);
        @(posedge clk);
        #1;
        req_v = req_v ^ mask;
        model_batch(mask);
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!((ack_w == req_v) && !busy) && cycles < budget);
        if (!((ack_w == req_v) && !busy))
            $display("timeout in %s: dbg_state=%0d acks=%b reqs=%b", tag, dbg_state, ack_w, req_v);
        check({tag, "_complete"}, 64'((ack_w == req_v) && !busy), 64'd1);
    endtask

    task automatic check_state(input string tag);
        int n;
        check({tag, "_n_xfer"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_xfer%0d_grant_addr", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
        end
        act_q.delete();
        exp_q.delete();
        check({tag, "_acks"}, 64'(ack_w), 64'(m_ack));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(data_w[i]), 64'(m_data[i]));
        end
        check({tag, "_grant_idle"}, 64'(grant), 64'd3);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic model_reset();
        m_ack = 3'b000;
        for (int i = 0; i < 3; i++) m_data[i] = 32'd0;
`ifdef GFX_ARB_ROUND_ROBIN_EN
        m_last = 2;
`endif
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_acks"}, 64'(ack_w), 64'd0);
        check({tag, "_sdr_req"}, 64'(bus.sdr_req), 64'd0);
        check({tag, "_sdr_addr"}, 64'(bus.sdr_addr), 64'd0);
        check({tag, "_grant"}, 64'(grant), 64'd3);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(data_w[i]), 64'd0);
        end
    endtask

    initial begin
        int          cyc;
        logic [28:0] first;
        logic        first_val;
        int          guard;
        logic [2:0]  mask;

        req_v = 3'b000;
        for (int i = 0; i < 3; i++) addr_v[i] = '0;
        model_reset();

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // single port 0 transfer, 1-clk downstream
        dly = 0;
        addr_v[0] = 21'h1F000;
        launch(3'b001);
        wait_done("single_p0", 50, cyc);
        check("single_p0_latency", 64'(cyc), 64'd4);
        first = (act_q.size() > 0) ? act_q[0] : '1;
        check("single_p0_sdr_addr", 64'(first[26:0]), 64'h11F000);
        check_state("single_p0");

        // all three ports toggle in the same cycle
        for (int i = 0; i < 3; i++) addr_v[i] = PADDR_W'($urandom);
        dly = 1;
        launch(3'b111);
        wait_done("all3", 100, cyc);
        check_state("all3");

        // port 1 re-toggles while its first transfer is stalled in WAIT
        dly = 20;
        addr_v[1] = PADDR_W'($urandom);
        launch(3'b010);
        first_val = req_v[1];
        repeat (4) @(posedge clk);
        #1;
        check("retoggle_busy", 64'(busy), 64'd1);
        check("retoggle_grant", 64'(grant), 64'd1);
        req_v[1] = ~req_v[1];
        model_serve(1);
        guard = 0;
        while (ack_w[1] !== first_val && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("retoggle_first_ack", 64'(ack_w[1]), 64'(first_val));
        check("retoggle_still_pending", 64'(ack_w[1] ^ req_v[1]), 64'd1);
        wait_done("retoggle", 200, cyc);
        check_state("retoggle");

        // address wrap on port 2
        dly = 1;
        addr_v[2] = 21'h20;
        launch(3'b100);
        wait_done("wrap", 50, cyc);
        first = (act_q.size() > 0) ? act_q[0] : '1;
        check("wrap_sdr_addr", 64'(first[26:0]), 64'h10);
        check_state("wrap");

        // randomized batches
        for (int it = 0; it < 12; it++) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                if (mask[i]) addr_v[i] = PADDR_W'($urandom);
            end
            dly = $urandom_range(0, 5);
            launch(mask);
            wait_done($sformatf("rand%0d", it), 200, cyc);
            check_state($sformatf("rand%0d", it));
        end

        // reset pulsed during WAIT
        dly = 20;
        addr_v[2] = PADDR_W'($urandom);
        launch(3'b100);
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        req_v   = 3'b000;
        #1;
        check_reset_values("mid_wait_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_no_xfer", 64'(act_q.size()), 64'd0);
        check_reset_values("post_reset_quiet");

        // arbiter usable again after reset
        dly = 2;
        for (int i = 0; i < 3; i++) addr_v[i] = PADDR_W'($urandom);
        launch(3'b111);
        wait_done("after_reset", 100, cyc);
        check_state("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
